// File: rtl/sid_bus_arb.sv
// -----------------------------------------------------------------------------
// sid_bus_arb
//
// Shares the single SID register port between two requesters. Every SID
// access happens in a slot that opens on the 1 MHz clkEn tick, and there is at
// most one access per slot.
//   Port A : host CPU. Reads and writes, held request, one-cycle acknowledge.
//   Port B : tune player. Writes only, buffered in a FIFO_DEPTH-entry FIFO.
//
// Optional feature (macro SID_ARB_FAIR_EN):
//   defined     - after two consecutive A grants while B has queued work,
//                 the next contended slot goes to B.
//   not defined - strict A priority. B is served only in slots where A is idle.
//
// Ports:
//   clk, iRstN            master clock, async active-low reset
//   clkEn                 slot enable, one clk wide, >= 4 clk apart
//   iAReq/iAWE/iAAddr/iAData, oAAck/oAData    port A request / completion
//   iBValid/iBAddr/iBData, oBReady/oBEmpty    port B FIFO push side
//   oWE/oAddr/oDataW, iDataR                  SID register port
// -----------------------------------------------------------------------------
module sid_bus_arb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       iRstN,
  input  logic       clkEn,
  input  logic       iAReq,
  input  logic       iAWE,
  input  logic [4:0] iAAddr,
  input  logic [7:0] iAData,
  output logic       oAAck,
  output logic [7:0] oAData,
  input  logic       iBValid,
  input  logic [4:0] iBAddr,
  input  logic [7:0] iBData,
  output logic       oBReady,
  output logic       oBEmpty,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oDataW,
  input  logic [7:0] iDataR
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_t;

  state_t state;

  // Port B FIFO storage and bookkeeping.
  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [7:0]       fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic slot;
  logic push;
  logic grant_a;
  logic grant_b;

  // A slot can only be used from IDLE; the clkEn spacing guarantees we are
  // back in IDLE before the next tick.
  assign slot = clkEn && (state == S_IDLE);

  // oBReady is the registered "not full" flag, so a push can never overflow.
  assign push = iBValid && oBReady;

`ifdef SID_ARB_FAIR_EN
  // Consecutive A grants while B has queued entries.
  logic [1:0] fair_cnt;

  assign grant_b = slot && !oBEmpty && (!iAReq || (fair_cnt == 2'd2));
`else
  assign grant_b = slot && !oBEmpty && !iAReq;
`endif
  assign grant_a = slot && iAReq && !grant_b;

  // NOTE: always_comb assigns every output up front, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, grant_b})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, so clearing them is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= iBAddr;
      fifo_data[wr_ptr] <= iBData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this clock edge.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= S_IDLE;
      oAAck   <= 1'b0;
      oAData  <= '0;
      oWE     <= 1'b0;
      oAddr   <= '0;
      oDataW  <= '0;
      oBReady <= 1'b1;
      oBEmpty <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      // Strobes are one-cycle pulses unless a state sets them below.
      oWE   <= 1'b0;
      oAAck <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count   <= count_nxt;
      oBReady <= (count_nxt != FULL_CNT);
      oBEmpty <= (count_nxt == '0);

      case (state)
        S_IDLE: begin
          if (grant_b) begin
            // The output registers double as the latched access fields.
            oWE    <= 1'b1;
            oAddr  <= fifo_addr[rd_ptr];
            oDataW <= fifo_data[rd_ptr];
            rd_ptr <= rd_ptr + PW'(1);
            state  <= S_WRITE;
          end else if (grant_a) begin
            oAddr <= iAAddr;
            if (iAWE) begin
              oWE    <= 1'b1;
              oDataW <= iAData;
              oAAck  <= 1'b1;
              state  <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ: begin
          // iDataR is combinational in oAddr, which has been stable all cycle.
          oAData <= iDataR;
          oAAck  <= 1'b1;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SID_ARB_FAIR_EN
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      fair_cnt <= '0;
    end else if (grant_b || oBEmpty) begin
      fair_cnt <= '0;
    end else if (grant_a && (fair_cnt != 2'd2)) begin
      fair_cnt <= fair_cnt + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sid_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_sid_bus_arb
//
// Scoreboard bench for sid_bus_arb. A transaction-level model, evaluated on
// the falling edge, watches the inputs the DUT is about to sample, decides
// who owns each slot and pushes the expected SID access (with the cycle it
// must appear in) into a queue. A monitor on the same edge pops and compares
// whenever the DUT shows oWE or oAAck. The SID itself is modelled as a fixed
// read function of the address. Honours SID_ARB_FAIR_EN like the design.
// -----------------------------------------------------------------------------
module tb_sid_bus_arb;

  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       iRstN   = 1'b0;
  logic       clkEn   = 1'b0;
  logic       iAReq   = 1'b0;
  logic       iAWE    = 1'b0;
  logic [4:0] iAAddr  = '0;
  logic [7:0] iAData  = '0;
  logic       iBValid = 1'b0;
  logic [4:0] iBAddr  = '0;
  logic [7:0] iBData  = '0;
  logic       oAAck;
  logic [7:0] oAData;
  logic       oBReady;
  logic       oBEmpty;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oDataW;
  logic [7:0] iDataR;

  sid_bus_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .iRstN   (iRstN),
    .clkEn   (clkEn),
    .iAReq   (iAReq),
    .iAWE    (iAWE),
    .iAAddr  (iAAddr),
    .iAData  (iAData),
    .oAAck   (oAAck),
    .oAData  (oAData),
    .iBValid (iBValid),
    .iBAddr  (iBAddr),
    .iBData  (iBData),
    .oBReady (oBReady),
    .oBEmpty (oBEmpty),
    .oWE     (oWE),
    .oAddr   (oAddr),
    .oDataW  (oDataW),
    .iDataR  (iDataR)
  );

  always #5 clk = ~clk;

  // SID read model: 0x1B reads back 0xA5, other addresses give other values.
  function automatic logic [7:0] rd_lut(input logic [4:0] a);
    logic [7:0] t;
    t = {3'b000, a ^ 5'h1B};
    return 8'hA5 ^ (t * 8'd7);
  endfunction

  assign iDataR = rd_lut(oAddr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    bit         is_rd;
    bit         ack;
    logic [4:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } bent_t;

  exp_t  expq[$];    // expected SID accesses / read completions
  exp_t  probeq[$];  // expected read-address cycles
  bent_t bq[$];      // model of the port B FIFO contents
  int    m_fair  = 0;
  int    cyc     = 0;
  bit    prev_ack = 1'b0;
  bit    slots_on = 1'b0;

  exp_t  e;
  bent_t b;
  bit    m_full, a_pend, b_pend, give_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, then model, on the falling edge.
  always @(negedge clk) begin
    if (!iRstN) begin
      expq.delete();
      probeq.delete();
      bq.delete();
      m_fair   = 0;
      prev_ack = 1'b0;
    end else begin
      // ---- monitor ----
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        check("missing_access_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (oAAck) check("ack_back_to_back", 32'(prev_ack), 32'd0);
      prev_ack = oAAck;
      if (probeq.size() > 0 && probeq[0].cyc == cyc) begin
        e = probeq.pop_front();
        check("rd_addr", 32'(oAddr), 32'(e.addr));
        check("rd_no_we", 32'(oWE), 32'd0);
      end
      if (oWE || oAAck) begin
        if (expq.size() == 0) begin
          check("unexpected_access", 32'({oWE, oAAck}), 32'd0);
        end else begin
          e = expq.pop_front();
          check("access_cycle", 32'(cyc), 32'(e.cyc));
          if (e.is_rd) begin
            check("rd_ack_we", 32'(oWE), 32'd0);
            check("rd_ack", 32'(oAAck), 32'd1);
            check("rd_data", 32'(oAData), 32'(e.data));
          end else begin
            check("wr_we", 32'(oWE), 32'd1);
            check("wr_addr", 32'(oAddr), 32'(e.addr));
            check("wr_data", 32'(oDataW), 32'(e.data));
            check("wr_owner_ack", 32'(oAAck), 32'(e.ack));
          end
        end
      end

      // ---- reference model for the coming edge ----
      m_full = (bq.size() >= DEPTH);
      if (bq.size() == 0) m_fair = 0;
      if (clkEn) begin
        a_pend = iAReq;
        b_pend = (bq.size() > 0);
`ifdef SID_ARB_FAIR_EN
        give_b = b_pend && (!a_pend || m_fair >= 2);
`else
        give_b = b_pend && !a_pend;
`endif
        if (give_b) begin
          b = bq.pop_front();
          expq.push_back('{1'b0, 1'b0, b.addr, b.data, cyc + 1});
          m_fair = 0;
        end else if (a_pend) begin
          if (b_pend) m_fair++;
          if (iAWE) begin
            expq.push_back('{1'b0, 1'b1, iAAddr, iAData, cyc + 1});
          end else begin
            probeq.push_back('{1'b0, 1'b0, iAAddr, 8'h00, cyc + 1});
            expq.push_back('{1'b1, 1'b1, 5'h00, rd_lut(iAAddr), cyc + 2});
          end
        end
      end
      if (iBValid && !m_full) bq.push_back('{iBAddr, iBData});
    end
  end

  // Slot generator: one-cycle clkEn pulses, 5..8 cycles apart.
  initial begin
    forever begin
      @(posedge clk);
      if (slots_on && iRstN) begin
        #1 clkEn = 1'b1;
        @(posedge clk);
        #1 clkEn = 1'b0;
        repeat ($urandom_range(3, 6)) @(posedge clk);
      end
    end
  end

  task automatic a_access(input logic we, input logic [4:0] addr, input logic [7:0] data);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    iAReq  = 1'b1;
    iAWE   = we;
    iAAddr = addr;
    iAData = data;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (oAAck) begin
        got = 1'b1;
        break;
      end
    end
    iAReq = 1'b0;
    if (!got) check("a_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic b_push(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    iBValid = 1'b1;
    iBAddr  = a;
    iBData  = d;
    @(posedge clk);
    #1;
    iBValid = 1'b0;
  endtask

  task automatic wait_b_empty(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (oBEmpty) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic quiesce();
    slots_on = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 iRstN = 1'b1;

    // Reset with three queued B entries.
    b_push(5'h02, 8'h33);
    b_push(5'h03, 8'h44);
    b_push(5'h07, 8'h55);
    check("pre_reset_not_empty", 32'(oBEmpty), 32'd0);
    iRstN = 1'b0;
    repeat (2) @(posedge clk);
    #1 iRstN = 1'b1;
    #1;
    check("reset_bempty", 32'(oBEmpty), 32'd1);
    check("reset_bready", 32'(oBReady), 32'd1);
    check("reset_we", 32'(oWE), 32'd0);
    check("reset_ack", 32'(oAAck), 32'd0);
    check("reset_adata", 32'(oAData), 32'd0);
    check("reset_addr", 32'(oAddr), 32'd0);
    check("reset_dataw", 32'(oDataW), 32'd0);
    slots_on = 1'b1;
    repeat (30) @(posedge clk);  // any access here is flagged by the monitor

    // Directed A write and read.
    a_access(1'b1, 5'h18, 8'h1F);
    a_access(1'b0, 5'h1B, 8'h00);
    check("rd_1b_held", 32'(oAData), 32'hA5);

    // B burst to full, plus one ignored offer while full.
    quiesce();
    b_push(5'h00, 8'h11);
    b_push(5'h01, 8'h22);
    b_push(5'h04, 8'h41);
    check("b_ready_before_full", 32'(oBReady), 32'd1);
    b_push(5'h05, 8'h09);
    check("b_full_ready", 32'(oBReady), 32'd0);
    b_push(5'h06, 8'h77);
    check("b_overflow_ignored", 32'(oBReady), 32'd0);
    slots_on = 1'b1;
    wait_b_empty("b_drain_empty");
    check("b_drain_ready", 32'(oBReady), 32'd1);

    // Contention: A pending continuously with two B entries queued.
    quiesce();
    b_push(5'h08, 8'hB1);
    b_push(5'h09, 8'hB2);
    fork
      begin
        for (int i = 0; i < 6; i++) a_access(1'b1, 5'(5'h10 + i), 8'(8'hC0 + i));
      end
      begin
        @(posedge clk);
        #2 slots_on = 1'b1;
      end
    join
    wait_b_empty("contention_drain");

    // Reset while in READ.
    a_access(1'b0, 5'h0A, 8'h00);
    check("rd_0a_held", 32'(oAData), 32'(rd_lut(5'h0A)));
    @(posedge clk);
    #1;
    iAReq  = 1'b1;
    iAWE   = 1'b0;
    iAAddr = 5'h03;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (clkEn) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_rd_slot_seen", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;
    check("rst_rd_addr", 32'(oAddr), 32'h03);
    iRstN = 1'b0;
    iAReq = 1'b0;
    #1;
    check("rst_rd_adata", 32'(oAData), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_rd_no_ack", 32'(oAAck), 32'd0);
    end
    iRstN = 1'b1;
    a_access(1'b1, 5'h11, 8'h5C);

    // Randomized mix of A accesses and B traffic.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 8)) @(posedge clk);
          a_access(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
        end
      end
      begin
        for (int i = 0; i < 500; i++) begin
          @(posedge clk);
          #1;
          iBValid = ($urandom_range(0, 3) == 0);
          iBAddr  = 5'($urandom);
          iBData  = 8'($urandom);
        end
        @(posedge clk);
        #1 iBValid = 1'b0;
      end
    join
    wait_b_empty("random_drain");
    repeat (20) @(posedge clk);
    check("exp_queue_drained", 32'(expq.size()), 32'd0);
    slots_on = 1'b0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sid_bus_arb.md
# sid_bus_arb

Register-bus arbiter sitting directly in front of the `sid` core. It shares the single SID register port (`iWE`/`iAddr`/`iDataW`/`oDataR`) between two requesters: the host CPU port (A: reads and writes, request/acknowledge) and a tune-player/sequencer port (B: writes only, buffered in a small FIFO). All SID accesses are issued in slots aligned to the 1 MHz `clkEn` tick, one access per slot.

## Interface
- `FIFO_DEPTH`, 4, port-B write FIFO depth in entries; power of two, ≥2.
- `clk`  in  1  master clock (same as `sid`).
- `iRstN`  in  1  reset; one clock, reset is asynchronous and active-low.
- `clkEn`  in  1  1 MHz slot enable; high for one `clk` cycle, at least 4 `clk` cycles apart.
- `iAReq`  in  1  port A request; held high with fields stable until `oAAck`.
- `iAWE`  in  1  port A: 1 = write, 0 = read.
- `iAAddr`  in  5  port A SID register address.
- `iAData`  in  8  port A write data.
- `oAAck`  out  1  port A one-cycle completion pulse.
- `oAData`  out  8  port A read data, valid while `oAAck`=1 and held until the next read completes.
- `iBValid`  in  1  port B write offer.
- `iBAddr`  in  5  port B address.
- `iBData`  in  8  port B data.
- `oBReady`  out  1  port B FIFO not full; push on `iBValid & oBReady`.
- `oBEmpty`  out  1  port B FIFO empty.
- `oWE`  out  1  to `sid.iWE`.
- `oAddr`  out  5  to `sid.iAddr`.
- `oDataW`  out  8  to `sid.iDataW`.
- `iDataR`  in  8  from `sid.oDataR` (combinational in `iAddr`).

## Operation
- Reset values: `oAAck`=0, `oAData`=0, `oWE`=0, `oAddr`=0, `oDataW`=0, `oBReady`=1, `oBEmpty`=1. FIFO, state and fairness counter are cleared. Asserting reset mid-access aborts it: no `oWE`, no `oAAck`, and queued B entries are lost.
- State machine: IDLE, WRITE, READ, CAPTURE.
  - IDLE: on a cycle with `clkEn`=1, arbitrate. A pending and chosen → latch A fields; go to WRITE if `iAWE`, otherwise READ. B chosen → pop FIFO head and go to WRITE. Nothing pending → stay in IDLE. With `clkEn`=0, stay in IDLE.
  - WRITE: `oWE`=1 for exactly this cycle, with `oAddr`/`oDataW` = latched fields. `oAAck`=1 the same cycle if the owner is A. Next state is IDLE.
  - READ: `oAddr` = A address, `oWE`=0. Next state is CAPTURE.
  - CAPTURE: `oAData` ← `iDataR` as sampled at the end of READ (registered). `oAAck`=1. Next state is IDLE.
- Arbitration: A has priority over B, subject to the fairness rule under Configuration.
- `oAddr`/`oDataW` hold their last driven values between accesses.
- FIFO: `oBReady` = !full and `oBEmpty` = empty, both registered from the occupancy count. A push and a pop in the same cycle leave the count unchanged. `iBValid` while full is ignored: no push, no overflow.
- An A request that appears after the `clkEn` cycle waits for the next slot. There is no request queue for A.

## Timing
- Slot decision is registered on the `clkEn` edge (cycle N). Write: `oWE` pulse in N+1. Read: address in N+1, `oAAck`/`oAData` in N+2.
- Port A write latency, from slot to ack: 1 clk. Read latency: 2 clk.
- At most one SID access per `clkEn` period. The state returns to IDLE before the next `clkEn` (guaranteed by the ≥4-cycle spacing).
- The FIFO push is visible to arbitration on the cycle after acceptance.
- `oAAck` is never high for two consecutive cycles.

## Configuration
- `SID_ARB_FAIR_EN` defined: a 2-bit counter counts consecutive A grants while the FIFO is non-empty.
  - When the count reaches 2 and both ports are pending, B receives the slot and the counter clears.
  - The counter also clears on any B grant, and whenever the FIFO is empty.
- Not defined: strict A priority. B is served only in slots where A is not pending; the counter logic is absent.

## Test plan
- Reset: `iRstN`=0 while the FIFO holds 3 entries, then release → `oBEmpty`=1, `oBReady`=1, `oWE`=0, and no access on the next 3 `clkEn` slots.
- A write 0x18←0x1F: `oWE`=1 for one cycle, one clk after the `clkEn` edge, with `oAddr`=0x18, `oDataW`=0x1F. `oAAck` pulses in the same cycle.
- A read 0x1B with `iDataR` model returning 0xA5 → `oAddr`=0x1B for one cycle, then `oAAck`=1 with `oAData`=0xA5. No `oWE` during the read.
- B burst: push 0x00←0x11, 0x01←0x22, 0x04←0x41, 0x05←0x09 (depth 4) → `oBReady`=0 after the 4th push. The four writes appear in order on 4 consecutive slots, and `oBEmpty`=1 after the last.
- Contention, A held continuously pending with 2 B entries queued:
  - with `SID_ARB_FAIR_EN`: grant order A,A,B,A,A,B;
  - without it: B is never granted until A stops requesting.
- Reset asserted in the READ state → no `oAAck`, `oAData`=0, and the state is IDLE after release.
